// File: rtl/ee354_numlock_keyer.sv
// ee354_numlock_keyer: keys a 4-bit combination into the EE354 number lock as timed U/Z presses and waits for Unlock.
// Define NUMLOCK_KEYER_RETRY_EN to resend the code once after a first WAIT_OPEN timeout.
module ee354_numlock_keyer #(
  parameter int PRESS_CYCLES = 5,
  parameter int GAP_CYCLES   = 3,
  parameter int OPEN_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] code,
  input  logic       Unlock,
  output logic       U,
  output logic       Z,
  output logic       busy,
  output logic       done,
  output logic       success
`ifdef NUMLOCK_KEYER_RETRY_EN
  ,
  output logic       attempt
`endif
);
  localparam int PG = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
  localparam int MX = (PG > OPEN_TIMEOUT) ? PG : OPEN_TIMEOUT;
  localparam int CW = $clog2(MX + 1);
  localparam logic [CW-1:0] P_LAST = CW'(PRESS_CYCLES - 1);
  localparam logic [CW-1:0] G_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] T_LAST = CW'(OPEN_TIMEOUT - 1);

`ifdef NUMLOCK_KEYER_RETRY_EN
  typedef enum logic [2:0] {IDLE, PRESS, GAP, WAIT_OPEN, DONE, RETRY} state_t;
`else
  typedef enum logic [2:0] {IDLE, PRESS, GAP, WAIT_OPEN, DONE} state_t;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    code_q, code_d;
  logic          success_q, success_d;
`ifdef NUMLOCK_KEYER_RETRY_EN
  logic          attempt_q, attempt_d;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      code_q    <= '0;
      success_q <= 1'b0;
`ifdef NUMLOCK_KEYER_RETRY_EN
      attempt_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      code_q    <= code_d;
      success_q <= success_d;
`ifdef NUMLOCK_KEYER_RETRY_EN
      attempt_q <= attempt_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    code_d    = code_q;
    success_d = success_q;
`ifdef NUMLOCK_KEYER_RETRY_EN
    attempt_d = attempt_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        state_d   = PRESS;
        code_d    = code;
        idx_d     = 2'd3;
        cnt_d     = '0;
        success_d = 1'b0;
`ifdef NUMLOCK_KEYER_RETRY_EN
        attempt_d = 1'b0;
`endif
      end
      PRESS: begin
        state_d = (cnt_q == P_LAST) ? GAP : PRESS;
        cnt_d   = (cnt_q == P_LAST) ? '0 : cnt_q + 1'b1;
      end
      GAP: if (cnt_q == G_LAST) begin
        state_d = (idx_q == 2'd0) ? WAIT_OPEN : PRESS;
        idx_d   = idx_q - 2'd1;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      // Unlock is checked before the timeout so a late Unlock still counts as success
      WAIT_OPEN: if (Unlock) begin
        state_d   = DONE;
        success_d = 1'b1;
        cnt_d     = '0;
      end else if (cnt_q == T_LAST) begin
        cnt_d = '0;
`ifdef NUMLOCK_KEYER_RETRY_EN
        state_d   = attempt_q ? DONE : RETRY;
        attempt_d = 1'b1;
`else
        state_d = DONE;
`endif
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
`ifdef NUMLOCK_KEYER_RETRY_EN
      RETRY: if (cnt_q == G_LAST) begin
        state_d = PRESS;
        idx_d   = 2'd3;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode the registered state, so reset clears them without waiting for clk
  assign U       = (state_q == PRESS) &&  code_q[idx_q];
  assign Z       = (state_q == PRESS) && !code_q[idx_q];
  assign busy    = (state_q != IDLE) && (state_q != DONE);
  assign done    = (state_q == DONE);
  assign success = success_q;
`ifdef NUMLOCK_KEYER_RETRY_EN
  assign attempt = attempt_q;
`endif
endmodule

// File: tb/tb_ee354_numlock_keyer.sv
// tb_ee354_numlock_keyer: directed self-checking bench for ee354_numlock_keyer at default parameters.
// Honours NUMLOCK_KEYER_RETRY_EN when the design is built with it.
module tb_ee354_numlock_keyer;
  logic clk, reset, start, Unlock, U, Z, busy, done, success;
  logic [3:0] code;
`ifdef NUMLOCK_KEYER_RETRY_EN
  logic attempt;
`endif
  int n_tests = 0, n_fail = 0, uz_bad = 0, dw_bad = 0;
  logic done_prev = 1'b0;
  logic [31:0] us, zs;
  int n;

  ee354_numlock_keyer dut (
    .clk(clk), .reset(reset), .start(start), .code(code), .Unlock(Unlock),
    .U(U), .Z(Z), .busy(busy), .done(done), .success(success)
`ifdef NUMLOCK_KEYER_RETRY_EN
    , .attempt(attempt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (U && Z) uz_bad++;
    if (done && done_prev) dw_bad++;
    done_prev = done;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [3:0] c);
    code  = c;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Records U/Z over the 32-cycle send; inj >= 0 pulses start with a different code at that cycle
  task automatic capture(input int inj, output logic [31:0] ou, output logic [31:0] oz);
    for (int j = 0; j < 32; j++) begin
      ou[j] = U;
      oz[j] = Z;
      if (j == inj) begin
        start = 1'b1;
        code  = 4'b0101;
      end else if (j == inj + 1) begin
        start = 1'b0;
      end
      tick();
    end
  endtask

  task automatic wait_done(input string tag, output int cyc);
    cyc = 0;
    while (!done && cyc < 200) begin
      tick();
      cyc++;
    end
    chk(tag, done, 1);
  endtask

  function automatic logic [31:0] exp_wave(input logic [3:0] c, input logic want_u);
    logic [31:0] e;
    logic b;
    for (int i = 0; i < 32; i++) begin
      b    = c[3 - i / 8];
      e[i] = (i % 8 < 5) && (want_u ? b : !b);
    end
    return e;
  endfunction

  initial begin
    reset = 1'b0; start = 1'b0; code = 4'b0; Unlock = 1'b0;
    #2;
    chk("rst_u", U, 0);
    chk("rst_z", Z, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_success", success, 0);
`ifdef NUMLOCK_KEYER_RETRY_EN
    chk("rst_attempt", attempt, 0);
`endif
    tick();
    reset = 1'b1;
    go(4'b1011);
    chk("s1_busy", busy, 1);
    capture(-1, us, zs);
    chk("s1_u", us, exp_wave(4'b1011, 1'b1));
    chk("s1_z", zs, exp_wave(4'b1011, 1'b0));
    chk("s1_wait_busy", busy, 1);
    repeat (3) tick();
    Unlock = 1'b1;
    chk("s1_no_done", done, 0);
    tick();
    Unlock = 1'b0;
    chk("s1_done", done, 1);
    chk("s1_success", success, 1);
    chk("s1_done_busy", busy, 0);
    start = 1'b1;
    code  = 4'b1011;
    tick();
    chk("s2_idle_busy", busy, 0);
    chk("s2_idle_done", done, 0);
    chk("s2_succ_hold", success, 1);
    tick();
    start = 1'b0;
    chk("s2_restart_busy", busy, 1);
    chk("s2_succ_clr", success, 0);
    repeat (9) tick();
    chk("r_press2_z", Z, 1);
    reset = 1'b0;
    #1;
    chk("r_u", U, 0);
    chk("r_z", Z, 0);
    chk("r_busy", busy, 0);
    tick();
    reset = 1'b1;
    go(4'b1101);
    chk("r_first_edge_busy", busy, 1);
    capture(-1, us, zs);
    chk("r_u_wave", us, exp_wave(4'b1101, 1'b1));
    chk("r_z_wave", zs, exp_wave(4'b1101, 1'b0));
    Unlock = 1'b1;
    tick();
    Unlock = 1'b0;
    chk("r_done", done, 1);
    chk("r_success", success, 1);
    tick();
    go(4'b0000);
    capture(-1, us, zs);
    chk("t_u_wave", us, 32'h0);
    chk("t_z_wave", zs, exp_wave(4'b0000, 1'b0));
`ifdef NUMLOCK_KEYER_RETRY_EN
    repeat (16) tick();
    chk("t_retry_attempt", attempt, 1);
    chk("t_retry_busy", busy, 1);
    chk("t_retry_done", done, 0);
    repeat (3) tick();
    capture(-1, us, zs);
    chk("t_retry_u", us, 32'h0);
    chk("t_retry_z", zs, exp_wave(4'b0000, 1'b0));
    repeat (15) tick();
    chk("t_pre_done", done, 0);
    tick();
    chk("t_done", done, 1);
    chk("t_attempt", attempt, 1);
`else
    repeat (15) tick();
    chk("t_pre_done", done, 0);
    tick();
    chk("t_done", done, 1);
`endif
    chk("t_success", success, 0);
    tick();
    Unlock = 1'b1;
    go(4'b0110);
    capture(-1, us, zs);
    chk("e_u_wave", us, exp_wave(4'b0110, 1'b1));
    chk("e_no_early", done, 0);
    chk("e_busy", busy, 1);
    Unlock = 1'b0;
    wait_done("e_bound", n);
`ifdef NUMLOCK_KEYER_RETRY_EN
    chk("e_cycles", n, 67);
`else
    chk("e_cycles", n, 16);
`endif
    chk("e_success", success, 0);
    tick();
    go(4'b1011);
    capture(10, us, zs);
    chk("i_u_wave", us, exp_wave(4'b1011, 1'b1));
    chk("i_z_wave", zs, exp_wave(4'b1011, 1'b0));
    Unlock = 1'b1;
    tick();
    Unlock = 1'b0;
    chk("i_done", done, 1);
    chk("i_success", success, 1);
    tick();
    go(4'b1001);
    capture(-1, us, zs);
    chk("l_u_wave", us, exp_wave(4'b1001, 1'b1));
    repeat (15) tick();
    Unlock = 1'b1;
    tick();
    Unlock = 1'b0;
    chk("l_done", done, 1);
    chk("l_success", success, 1);
    tick();
    tick();
    chk("uz_never", uz_bad, 0);
    chk("done_width", dw_bad, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
